// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   state_t      - arbiter FSM states
//   REQ_*        - requester index constants (fetch, data, debug)
//   ADDR_W/DATA_W- word address and data widths
//   TIMEOUT_DEF  - default wait limit for mem_ready
//   next_ptr()   - round-robin pointer following a one-hot winner
package mem_arb_pkg;

    localparam int NUM_REQ     = 3;
    localparam int ADDR_W      = 6;
    localparam int DATA_W      = 16;
    localparam int TIMEOUT_DEF = 15;

    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_DBG   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Search for the next grant starts one past the requester just served.
    function automatic logic [1:0] next_ptr(input logic [NUM_REQ-1:0] win);
        case (win)
            3'b001:  next_ptr = 2'd1;
            3'b010:  next_ptr = 2'd2;
            default: next_ptr = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick: combinational winner selection for the memory port arbiter.
//   req [2:0] - active requests (bit0 fetch, bit1 data, bit2 debug)
//   ptr [1:0] - round-robin search start (only with MEM_ARB_RR_EN)
//   win [2:0] - one-hot winner, zero when no request is active
// Build option: MEM_ARB_RR_EN selects round-robin; otherwise fixed
// priority data > fetch > debug.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
`ifdef MEM_ARB_RR_EN
    input  logic [1:0]         ptr,
`endif
    output logic [NUM_REQ-1:0] win
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        win = '0;
        case (ptr)
            2'd1: begin
                if      (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
            end
            2'd2: begin
                if      (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
            end
            default: begin
                if      (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
            end
        endcase
    end
`else
    always_comb begin
        win = '0;
        if      (req[REQ_DATA])  win[REQ_DATA]  = 1'b1;
        else if (req[REQ_FETCH]) win[REQ_FETCH] = 1'b1;
        else if (req[REQ_DBG])   win[REQ_DBG]   = 1'b1;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch, data and
// debug requesters. One access at a time: IDLE -> ACCESS -> DONE -> IDLE.
//   clk_main, reset        - clock, async active-low reset
//   req/req_we             - per-requester request and write enable
//   req_addr/req_wdata     - packed per-requester address and write data
//   gnt                    - one-hot grant held through ACCESS and DONE
//   done/err/rdata         - completion pulse, timeout flag, read data
//   mem_en/mem_we/mem_addr/mem_wdata - memory request
//   mem_rdata/mem_ready    - memory response (ready is a one-cycle pulse)
// Build option: MEM_ARB_RR_EN enables round-robin arbitration.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                        clk_main,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic                        err,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_ready
);

    localparam logic [3:0] TO_LIM = 4'(TIMEOUT);

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  gnt_r, win;
    logic [ADDR_W-1:0]   addr_r, addr_sel;
    logic [DATA_W-1:0]   wdata_r, wdata_sel, rdata_r;
    logic                we_r, we_sel, err_r;
    logic [3:0]          cnt, cnt_inc;

    assign cnt_inc = cnt + 4'd1;

`ifdef MEM_ARB_RR_EN
    logic [1:0] ptr;
    arb_pick u_pick (.req(req), .ptr(ptr), .win(win));
`else
    arb_pick u_pick (.req(req), .win(win));
`endif

    // Operands of the winning requester; fetch can never write.
    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        we_sel    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                addr_sel  = req_addr[ADDR_W*i +: ADDR_W];
                wdata_sel = req_wdata[DATA_W*i +: DATA_W];
                we_sel    = (i != REQ_FETCH) && req_we[i];
            end
        end
    end

    // A ready in the cycle the counter would hit the limit wins over timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = ACCESS;
            ACCESS:  if (mem_ready || cnt_inc == TO_LIM) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gnt_r   <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            we_r    <= 1'b0;
            cnt     <= '0;
            err_r   <= 1'b0;
            rdata_r <= '0;
`ifdef MEM_ARB_RR_EN
            ptr     <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt_r   <= win;
                        addr_r  <= addr_sel;
                        wdata_r <= wdata_sel;
                        we_r    <= we_sel;
                        cnt     <= '0;
`ifdef MEM_ARB_RR_EN
                        ptr     <= next_ptr(win);
`endif
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        rdata_r <= mem_rdata;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == TO_LIM) begin
                            err_r   <= 1'b1;
                            rdata_r <= '0;
                        end
                    end
                end
                DONE: begin
                    gnt_r <= '0;
                    err_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Decoded from state so reset drops mem_en and gnt without a clock.
    assign gnt       = gnt_r;
    assign done      = (state == DONE) ? gnt_r : '0;
    assign err       = (state == DONE) && err_r;
    assign rdata     = rdata_r;
    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en && we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk_main = 1'b0;
    logic        reset    = 1'b0;
    logic [2:0]  req      = '0;
    logic [2:0]  req_we   = '0;
    logic [17:0] req_addr = '0;
    logic [47:0] req_wdata = '0;
    logic [2:0]  gnt, done;
    logic        err, mem_en, mem_we;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic [5:0]  mem_addr;
    logic        mem_ready;
    logic        rdy_resp = 1'b0, rdy_stray = 1'b0;
    logic [15:0] rd_resp = '0;

    always #5 clk_main = ~clk_main;

    assign mem_ready = rdy_resp | rdy_stray;
    assign mem_rdata = rdy_stray ? 16'hDEAD : rd_resp;

    mem_port_arbiter #(.TIMEOUT(15)) dut (
        .clk_main(clk_main), .reset(reset), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .err(err), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    typedef struct {
        logic [2:0]  win;
        logic        err;
        logic [15:0] rdata;
        logic [5:0]  addr;
        logic        we;
        logic [15:0] wdata;
        int          lat;   // ACCESS cycle carrying mem_ready; 0 = never
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0, errors = 0;
    int          n_done = 0;
    int          acc_cnt = 0;
    logic        prev_en = 1'b0;
    int          ref_ptr = 0;
    logic [15:0] last_rdata = '0;
    logic [15:0] ref_mem[64];
    logic [15:0] mem_arr[64];
    logic [5:0]  a_addr[3];
    logic [15:0] a_wdata[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Arbitration rule straight from the requirements.
    function automatic int pick(input logic [2:0] r, input int p);
        int idx;
        int pri[3];
`ifdef MEM_ARB_RR_EN
        for (int k = 0; k < 3; k++) begin
            idx = (p + k) % 3;
            if (r[idx[1:0]]) return idx;
        end
`else
        pri = '{1, 0, 2};
        for (int k = 0; k < 3; k++) begin
            idx = pri[k];
            if (r[idx[1:0]]) return idx;
        end
`endif
        return -1;
    endfunction

    // Memory responder: checks request stability and answers after lat cycles.
    initial begin
        forever begin
            @(negedge clk_main);
            rdy_resp = 1'b0;
            rd_resp  = 16'($urandom);
            if (mem_en) begin
                if (!prev_en) acc_cnt = 0;
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_mem_en");
                end else begin
                    chk("mem_addr", mem_addr, exp_q[0].addr);
                    chk("mem_we", mem_we, exp_q[0].we);
                    if (exp_q[0].we) chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                    chk("gnt_access", gnt, exp_q[0].win);
                    if (acc_cnt == exp_q[0].lat) begin
                        rdy_resp = 1'b1;
                        rd_resp  = mem_arr[mem_addr];
                        if (mem_we) mem_arr[mem_addr] = mem_wdata;
                    end
                end
            end
            prev_en = mem_en;
        end
    end

    // Monitor: pops one expectation per done pulse.
    initial begin
        forever begin
            @(negedge clk_main);
            if (done !== 3'b000) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done", done, mon_e.win);
                    chk("gnt_done", gnt, mon_e.win);
                    chk("err", err, mon_e.err);
                    chk("rdata", rdata, mon_e.rdata);
                    chk("access_cycles", acc_cnt, (mon_e.lat == 0) ? 15 : mon_e.lat);
                    last_rdata = mon_e.rdata;
                end
                n_done++;
            end else begin
                chk("err_idle", err, 1'b0);
            end
        end
    end

    task automatic drive_ops(input logic [2:0] wv);
        for (int i = 0; i < 3; i++) begin
            req_addr[6*i +: 6]   = a_addr[i];
            req_wdata[16*i +: 16] = a_wdata[i];
        end
        req_we = wv;
    endtask

    // Holds rv until each requester is served once; caller is at negedge+2 in IDLE.
    task automatic serve_set(input logic [2:0] rv, input logic [2:0] wv, input int lat, input bit drop_mid);
        logic [2:0] cur;
        exp_t e;
        int w, start;
        bit got, first;
        cur = rv;
        first = 1'b1;
        drive_ops(wv);
        while (cur != 3'b000) begin
            w = pick(cur, ref_ptr);
            e.win   = 3'b001 << w;
            e.we    = (w != 0) && wv[w[1:0]];
            e.addr  = a_addr[w];
            e.wdata = a_wdata[w];
            e.lat   = lat;
            e.err   = (lat == 0);
            e.rdata = e.err ? 16'h0000 : ref_mem[e.addr];
            if (!e.err && e.we) ref_mem[e.addr] = e.wdata;
`ifdef MEM_ARB_RR_EN
            ref_ptr = (w + 1) % 3;
`endif
            exp_q.push_back(e);
            start = n_done;
            if (first) begin
                req = cur;
                @(negedge clk_main); #1;
                chk("latency_mem_en", mem_en, 1'b1);
                chk("latency_gnt", gnt, e.win);
                if (drop_mid) req = 3'b000;
                first = 1'b0;
            end
            got = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk_main); #2;
                if (n_done != start) begin got = 1'b1; break; end
            end
            if (!got) begin
                fail_now("done_timeout");
                exp_q.delete();
            end
            cur = drop_mid ? 3'b000 : (cur & ~e.win);
            req = cur;
        end
        @(negedge clk_main); #2;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 16'($urandom);
            mem_arr[i] = ref_mem[i];
        end
        ref_mem[5] = 16'hA5A5;
        mem_arr[5] = 16'hA5A5;

        // Reset state
        #3;
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_done", done, 3'b000);
        chk("rst_err", err, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_mem_addr", mem_addr, 6'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        repeat (2) @(negedge clk_main);
        #2 reset = 1'b1;
        @(negedge clk_main); #2;

        // All three requesting, twice (pointer wraps back to fetch under RR)
        for (int i = 0; i < 3; i++) begin a_addr[i] = 6'(i + 8); a_wdata[i] = 16'($urandom); end
        serve_set(3'b111, 3'b000, 2, 1'b0);
        serve_set(3'b111, 3'b000, 1, 1'b0);

        // Single fetch, ready in third ACCESS cycle
        a_addr[0] = 6'h05;
        serve_set(3'b001, 3'b000, 3, 1'b0);
        // Fetch with we set must still read
        serve_set(3'b001, 3'b001, 2, 1'b0);

        // Data write then read back
        a_addr[1] = 6'h3F; a_wdata[1] = 16'h1234;
        serve_set(3'b010, 3'b010, 4, 1'b0);
        serve_set(3'b010, 3'b000, 2, 1'b0);

        // Timeout and the ready-on-last-cycle boundary
        a_addr[2] = 6'h11;
        serve_set(3'b100, 3'b000, 0, 1'b0);
        serve_set(3'b100, 3'b000, 15, 1'b0);
        serve_set(3'b100, 3'b000, 14, 1'b0);

        // Request dropped mid-access, then a stray ready in IDLE
        a_addr[1] = 6'h22;
        serve_set(3'b010, 3'b000, 3, 1'b1);
        rdy_stray = 1'b1;
        @(negedge clk_main); #1;
        rdy_stray = 1'b0;
        chk("stray_rdata", rdata, last_rdata);
        chk("stray_mem_en", mem_en, 1'b0);
        chk("stray_gnt", gnt, 3'b000);
        chk("stray_done", done, 3'b000);
        #1;

        // Reset during the third ACCESS cycle
        drive_ops(3'b000);
        begin
            exp_t e;
            e.win = 3'b001; e.we = 1'b0; e.addr = a_addr[0]; e.wdata = a_wdata[0];
            e.lat = 0; e.err = 1'b1; e.rdata = 16'h0;
            exp_q.push_back(e);
        end
        req = 3'b001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_main); #2;
            if (mem_en && acc_cnt == 3) break;
        end
        chk("pre_rst_mem_en", mem_en, 1'b1);
        start = n_done;
        reset = 1'b0;
        #1;
        chk("arst_mem_en", mem_en, 1'b0);
        chk("arst_gnt", gnt, 3'b000);
        chk("arst_done", done, 3'b000);
        exp_q.delete();
        ref_ptr = 0;
        last_rdata = '0;
        req = 3'b000;
        repeat (3) @(negedge clk_main);
        #2;
        chk("arst_no_done", n_done, start);
        chk("arst_rdata", rdata, 16'h0);
        reset = 1'b1;
        @(negedge clk_main); #2;
        a_addr[0] = 6'h07;
        serve_set(3'b001, 3'b000, 2, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            int lat;
            for (int i = 0; i < 3; i++) begin
                a_addr[i]  = 6'($urandom);
                a_wdata[i] = 16'($urandom);
            end
            lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            serve_set(3'($urandom_range(1, 7)), 3'($urandom), lat, ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 15, maximum wait cycles for mem_ready before an access aborts (legal range 1..15).
REQ-002 The block SHALL have the port clk_main  in  1  sole clock, rising-edge.
REQ-003 The block SHALL have the port reset  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have the port req  in  3  request per requester: bit0 fetch, bit1 data load/store, bit2 debug/IO.
REQ-005 The block SHALL have the port req_we  in  3  write enable per requester; req_we[0] is ignored (fetch is read-only).
REQ-006 The block SHALL have the port req_addr  in  18  three 6-bit word addresses, requester i at bits [6i+5:6i].
REQ-007 The block SHALL have the port req_wdata  in  48  three 16-bit write words, requester i at bits [16i+15:16i].
REQ-008 The block SHALL have the port gnt  out  3  one-hot grant, held for the whole access.
REQ-009 The block SHALL have the port done  out  3  one-cycle completion pulse to the granted requester.
REQ-010 The block SHALL have the port err  out  1  one-cycle pulse with done when the access timed out.
REQ-011 The block SHALL have the port rdata  out  16  read data, valid in the done cycle.
REQ-012 The block SHALL have the ports mem_en out 1, mem_we out 1, mem_addr out 6 and mem_wdata out 16, which form the single-port memory request.
REQ-013 The block SHALL have the ports mem_rdata in 16 and mem_ready in 1, which carry the memory response; mem_ready is a one-cycle pulse.

Function
REQ-014 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-015 In IDLE with any req bit high, the block SHALL pick a winner, register its gnt bit, address, wdata and we (forced to 0 for requester 0), and move to ACCESS on the next edge.
REQ-016 In ACCESS, mem_en SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL be driven from the registered values, stable until exit.
REQ-017 In ACCESS, when mem_ready=1, the block SHALL capture mem_rdata into rdata and go to DONE.
REQ-018 The wait counter SHALL clear on entry to ACCESS and increment once per ACCESS cycle without mem_ready; on reaching TIMEOUT, the block SHALL go to DONE with the error flag set and rdata=16'h0000.
REQ-019 In DONE, done[winner] SHALL be 1 for exactly one cycle, with err equal to the error flag; the block SHALL then clear gnt and the error flag and return to IDLE.
REQ-020 Minimum latency SHALL be: req sampled at edge N, mem_en high in cycle N+1, done high in the cycle after mem_ready.
REQ-021 Requests SHALL be level-sensitive; a req dropped while granted SHALL NOT abort the access, and done SHALL still pulse.
REQ-022 Changes on req/addr/wdata during ACCESS or DONE SHALL be ignored.
REQ-023 A mem_ready arriving in the same cycle the counter reaches TIMEOUT SHALL count as success (err=0).
REQ-024 mem_ready outside ACCESS SHALL be ignored.
REQ-025 At most one gnt bit and one done bit SHALL be high at any time.

Reset
REQ-026 While reset=0, the FSM SHALL be in IDLE; gnt, done, err, mem_en and mem_we SHALL be 0; rdata, mem_addr and mem_wdata SHALL be 0; the counter SHALL be 0; the round-robin pointer SHALL be 0.
REQ-027 Reset asserted during ACCESS SHALL abandon the access immediately with no done pulse, and mem_en SHALL fall asynchronously.

Configuration
REQ-028 With MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: search starts at the requester after the last winner, and the pointer updates on each IDLE->ACCESS transition.
REQ-029 Without MEM_ARB_RR_EN, arbitration SHALL be fixed priority (bit1 data > bit0 fetch > bit2 debug) and no pointer register SHALL exist.

Structure
REQ-030 A package mem_arb_pkg SHALL hold the state enum, the requester index constants (REQ_FETCH=0, REQ_DATA=1, REQ_DBG=2), the address/data widths (6/16) and the TIMEOUT default.
REQ-031 One combinational sub-module, arb_pick, SHALL map req plus pointer to a one-hot winner; the FSM, registers and counter SHALL stay in mem_port_arbiter.

Verification
REQ-032 The bench SHALL cover this scenario: single fetch, req=001 with addr0=6'h05 and mem_ready 2 cycles after mem_en, mem_rdata=16'hA5A5 -> gnt=001, mem_we=0, done=001 one cycle, rdata=16'hA5A5, err=0.
REQ-033 The bench SHALL cover this scenario: simultaneous req=111, fixed priority -> grant order data, fetch, debug; with MEM_ARB_RR_EN -> order fetch, data, debug, then fetch again on the next req=111.
REQ-034 The bench SHALL cover this scenario: data write, req_we=010, addr1=6'h3F, wdata1=16'h1234 -> mem_we=1, mem_addr=6'h3F, mem_wdata=16'h1234 held until mem_ready.
REQ-035 The bench SHALL cover this scenario: no mem_ready with TIMEOUT=15 -> after 15 ACCESS cycles, done pulses with err=1 and rdata=0, then the block returns to IDLE.
REQ-036 The bench SHALL cover this scenario: reset driven 0 in the 3rd ACCESS cycle -> mem_en=0 and gnt=000 immediately, no done; the next request after release is served normally.
REQ-037 The bench SHALL cover this scenario: req dropped mid-access and a mem_ready pulse in IDLE -> the access still completes with done, and the stray mem_ready causes no output change.
